// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/XNOR) with valid/ready handshakes,
// a stall-all pipeline, a post-reset initialisation delay and a transfer counter.
module logic_pipe #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 2,
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [IW-1:0]                init_cnt;
    logic                         advance;
    logic                         accept;
    logic [WIDTH-1:0]             result;
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][WIDTH-1:0]  dat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_cnt == IW'(INIT_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        ready = (state == S_RUN);
    end

    always_comb begin
        result = '0;
        case (op)
            2'd0:    result = a & b;
            2'd1:    result = a | b;
            2'd2:    result = a ^ b;
            default: result = ~(a ^ b);
        endcase
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = ready && advance;
    assign accept   = in_valid && in_ready;

    // Bubbles load zero so stage data never carries X from idle inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            dat <= '0;
        end else if (advance) begin
            vld[0] <= accept;
            dat[0] <= accept ? result : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign c         = dat[DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xfer_count <= '0;
        else if (out_valid && out_ready)
            xfer_count <= xfer_count + 1'b1;
    end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined bitwise logic unit with valid/ready handshakes on both sides, a run-time operation select and a post-reset initialisation delay.
- Successor to the single-bit XOR gate.
- Generalises it in data width, operation mode, pipeline depth and output backpressure.
- Sits between a stimulus source and a result sink in the example designs.
- Its `ready` output keeps the meaning of "block is out of initialisation and accepting work".

## Interface
- `WIDTH`, 8: data width of `a`, `b`, `c`; ≥1.
- `DEPTH`, 2: number of pipeline register stages; ≥1.
- `INIT_CYCLES`, 4: clock edges after reset release before `ready` rises; ≥1.
- `CNT_W`, 16: width of the transfer counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ready`  out  1  initialisation complete.
- `op`  in  2  operation: 0 = AND, 1 = OR, 2 = XOR, 3 = XNOR.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `in_valid`  in  1  operands and `op` valid.
- `in_ready`  out  1  operands accepted this cycle.
- `c`  out  WIDTH  result.
- `out_valid`  out  1  `c` valid.
- `out_ready`  in  1  sink accepts `c`.
- `xfer_count`  out  CNT_W  number of completed output transfers.

## Operation
- **States:** INIT → RUN.
  - Reset forces INIT and clears the init counter.
  - In INIT the counter increments each edge.
  - On the edge where the counter equals INIT_CYCLES−1, the state goes to RUN and `ready` becomes 1.
  - RUN is held until reset.
- **Datapath:** DEPTH stages, each holding a valid bit and a WIDTH-bit result.
  - Stage 1 captures f(op, a, b), computed combinationally at acceptance.
  - `op` is sampled per transaction, so different ops may be in flight at once.
- **Stall-all pipeline:**
  - `advance` = !out_valid || out_ready.
  - When `advance`=1, every stage shifts one position.
  - Stage 1 loads valid = (in_valid && in_ready).
  - When `advance`=0, all stages hold.
- **Input handshake:** `in_ready` = ready && advance (combinational). Acceptance is `in_valid && in_ready`.
- **Output:** `out_valid` and `c` are the last stage's valid bit and data.
  - While `out_valid && !out_ready`, `c` and `out_valid` stay stable.
  - `out_valid`, once asserted, never drops without a transfer.
- **Counter:** `xfer_count` increments by 1 on each edge with `out_valid && out_ready`. It wraps from 2^CNT_W−1 to 0.
- **Simultaneous accept and transfer** in the same cycle is legal, and that is how 1-per-cycle throughput is sustained.
- `in_valid` while `ready`=0 is ignored and nothing is captured.
- **Bubbles:** when `in_valid`=0 and `advance`=1, a bubble (valid=0) enters stage 1. Stage data for bubbles is don't-care, but `c` is driven from the register and never X-propagated from undriven inputs.

## Timing
- **Reset values (asynchronous, immediate):**
  - `ready`=0, `in_ready`=0, `out_valid`=0, `c`=0, `xfer_count`=0.
  - All stage valid bits 0; init counter 0.
- **Init:** `ready` rises after the INIT_CYCLES-th rising edge following reset deassertion.
- **Latency:** with no backpressure, a transaction accepted at edge N appears with `out_valid`=1 after edge N+DEPTH−1, i.e. DEPTH cycles.
- **Throughput:** one transaction per cycle while `out_ready`=1.
- **Backpressure:** `out_ready` low with `out_valid` high drops `in_ready` in the same cycle; there is no skid capacity.
- **Reset mid-operation:** all in-flight data is discarded, the counter clears, and INIT restarts. No output transfer occurs on the reset edge.

## Test plan
All scenarios use WIDTH=8, DEPTH=2, INIT_CYCLES=4.
1. **Reset and init:** reset held then released.
   - Outputs read 0 during reset.
   - `ready` and `in_ready` are 0 for 3 edges and 1 after the 4th.
   - `in_valid` asserted during INIT produces no `out_valid`.
2. **All ops, one per cycle, `out_ready`=1:** a=0xF0, b=0x3C, op=0,1,2,3.
   - `c` = 0x30, 0xFC, 0xCC, 0x33 on consecutive cycles.
   - Each result arrives 2 cycles after acceptance.
   - `xfer_count`=4 at the end.
3. **Backpressure:** stream 6 XOR transactions (a=i, b=0xFF) with `out_ready` low for 3 cycles mid-stream.
   - `c` holds stable during the stall and `in_ready` is 0.
   - Results arrive in order as 0xFF−i with no loss or duplication.
   - `xfer_count`=6.
4. **Bubbles:** alternating `in_valid`, a=0xAA, b=0x55, op=3.
   - `out_valid` alternates 1/0.
   - Every valid `c`=0x00.
5. **Counter wrap:** use CNT_W=3 and perform 9 transfers.
   - `xfer_count` reads 1 after the 9th transfer.
6. **Reset mid-stream:** assert reset with 2 transactions in flight.
   - `out_valid`, `ready` and `xfer_count` go to 0 immediately.
   - No stale result appears after the new INIT completes.
